// File: rtl/gdsp_pkg.sv
// Shared types and constants for the TX DSP chain.
package gdsp_pkg;

    localparam int unsigned GDSP_SPS = 4;

    typedef enum logic [1:0] {
        SegIdle  = 2'd0,
        SegPre   = 2'd1,
        SegPay   = 2'd2,
        SegGuard = 2'd3
    } frame_seg_t;

    localparam logic [3:0] PRE_SYM_A = 4'h3;
    localparam logic [3:0] PRE_SYM_B = 4'hC;

endpackage

// File: rtl/prbs23_step4.sv
// PRBS-23 (x^23 + x^18 + 1) Fibonacci LFSR advanced four steps in one cycle.
// The first generated bit lands in bits[3].
module prbs23_step4 (
    input  logic [22:0] state,
    output logic [22:0] next_state,
    output logic [3:0]  bits
);

    logic [22:0] s;
    logic        fb;

    always_comb begin
        s    = state;
        fb   = 1'b0;
        bits = '0;
        for (int i = 0; i < 4; i++) begin
            fb          = s[22] ^ s[17];
            bits[3 - i] = fb;
            s           = {s[21:0], fb};
        end
        next_state = s;
    end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Burst framer: preamble, PRBS-23 payload and guard gap on a fixed symbol grid of one
// symbol every SPS enabled clocks, single-shot or back-to-back.
module tx_frame_ctrl
    import gdsp_pkg::*;
#(
    parameter int unsigned SPS       = GDSP_SPS,
    parameter int unsigned PRE_LEN   = 16,
    parameter int unsigned GUARD_LEN = 8,
    parameter int unsigned LEN_W     = 10,
    parameter logic [22:0] PRBS_SEED = 23'h7FFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    input  logic [LEN_W-1:0] payload_len,
    output logic [3:0]       sym_bits,
    output logic             sym_valid,
    output logic             sym_tick,
    output logic [1:0]       seg,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count
);

    localparam int unsigned DIV_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int unsigned CNT_W = (LEN_W > 16) ? LEN_W : 16;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StPay,
        StGuard
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] slot_q;
    logic [LEN_W-1:0] len_q;
    logic             cont_q;
    logic             stop_pend_q;
    logic [22:0]      lfsr_q;
    logic [22:0]      lfsr_nxt;
    logic [3:0]       prbs_bits;

    logic [3:0]       sym_bits_q;
    logic             sym_valid_q;
    logic             sym_tick_q;
    frame_seg_t       seg_q;
    logic             busy_q;
    logic             frame_done_q;
    logic [15:0]      frame_count_q;

    logic slot_due;
    logic div_wrap;
    logic pre_last;
    logic pay_last;
    logic guard_last;
    logic stop_now;

    prbs23_step4 u_prbs (
        .state      (lfsr_q),
        .next_state (lfsr_nxt),
        .bits       (prbs_bits)
    );

    assign slot_due   = (div_q == '0);
    assign div_wrap   = (div_q == DIV_W'(SPS - 1));
    assign pre_last   = (slot_q == CNT_W'(PRE_LEN - 1));
    assign pay_last   = (slot_q == CNT_W'(len_q) - CNT_W'(1));
    assign guard_last = (slot_q == CNT_W'(GUARD_LEN - 1));
    // A stop arriving on the final guard slot still ends a continuous run.
    assign stop_now   = stop_pend_q | stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            div_q         <= '0;
            slot_q        <= '0;
            len_q         <= '0;
            cont_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            lfsr_q        <= PRBS_SEED;
            sym_bits_q    <= '0;
            sym_valid_q   <= 1'b0;
            sym_tick_q    <= 1'b0;
            seg_q         <= SegIdle;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else if (!en) begin
            sym_valid_q  <= 1'b0;
            sym_tick_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sym_valid_q  <= 1'b0;
            sym_tick_q   <= 1'b0;
            frame_done_q <= 1'b0;

            if (state_q != StIdle) begin
                div_q <= div_wrap ? '0 : div_q + DIV_W'(1);
                if (stop) begin
                    stop_pend_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    seg_q       <= SegIdle;
                    sym_bits_q  <= '0;
                    busy_q      <= 1'b0;
                    stop_pend_q <= 1'b0;
                    if (start) begin
                        state_q     <= StPre;
                        len_q       <= payload_len;
                        cont_q      <= continuous;
                        stop_pend_q <= stop;
                        lfsr_q      <= PRBS_SEED;
                        div_q       <= '0;
                        slot_q      <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                StPre: begin
                    if (slot_due) begin
                        sym_tick_q  <= 1'b1;
                        sym_valid_q <= 1'b1;
                        seg_q       <= SegPre;
                        sym_bits_q  <= slot_q[0] ? PRE_SYM_B : PRE_SYM_A;
                        if (pre_last) begin
                            slot_q  <= '0;
                            state_q <= (len_q == '0) ? StGuard : StPay;
                        end else begin
                            slot_q <= slot_q + CNT_W'(1);
                        end
                    end
                end
                StPay: begin
                    if (slot_due) begin
                        sym_tick_q  <= 1'b1;
                        sym_valid_q <= 1'b1;
                        seg_q       <= SegPay;
                        sym_bits_q  <= prbs_bits;
                        lfsr_q      <= lfsr_nxt;
                        if (pay_last) begin
                            slot_q  <= '0;
                            state_q <= StGuard;
                        end else begin
                            slot_q <= slot_q + CNT_W'(1);
                        end
                    end
                end
                StGuard: begin
                    if (slot_due) begin
                        sym_tick_q <= 1'b1;
                        seg_q      <= SegGuard;
                        sym_bits_q <= '0;
                        if (guard_last) begin
                            slot_q        <= '0;
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                            if (cont_q && !stop_now) begin
                                state_q <= StPre;
                                lfsr_q  <= PRBS_SEED;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            slot_q <= slot_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sym_bits    = sym_bits_q;
    assign sym_valid   = sym_valid_q & en;
    assign sym_tick    = sym_tick_q & en;
    assign frame_done  = frame_done_q & en;
    assign seg         = seg_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed/randomised bench for tx_frame_ctrl against a frame-level reference model.
module tb_tx_frame_ctrl;

    localparam int unsigned SPS       = 4;
    localparam int unsigned PRE_LEN   = 16;
    localparam int unsigned GUARD_LEN = 8;
    localparam int unsigned LEN_W     = 10;
    localparam logic [22:0] SEED      = 23'h7FFFFF;

    typedef struct {
        logic [1:0] seg;
        logic [3:0] bits;
        logic       valid;
    } slot_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             start;
    logic             continuous;
    logic             stop;
    logic [LEN_W-1:0] payload_len;
    logic [3:0]       sym_bits;
    logic             sym_valid;
    logic             sym_tick;
    logic [1:0]       seg;
    logic             busy;
    logic             frame_done;
    logic [15:0]      frame_count;

    int checks = 0;
    int errors = 0;
    int fc_exp = 0;
    int len_r;

    tx_frame_ctrl #(
        .SPS       (SPS),
        .PRE_LEN   (PRE_LEN),
        .GUARD_LEN (GUARD_LEN),
        .LEN_W     (LEN_W),
        .PRBS_SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .continuous  (continuous),
        .stop        (stop),
        .payload_len (payload_len),
        .sym_bits    (sym_bits),
        .sym_valid   (sym_valid),
        .sym_tick    (sym_tick),
        .seg         (seg),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One frame as a list of symbol slots; payload from the sequence recurrence
    // b[n+23] = b[n] ^ b[n+5], b[0..22] = seed MSB first.
    task automatic run_frame(input int len, input int first_delay, input int gap_slot,
                             input int pulse_slot, input int pulse_kind);
        slot_t       exp_q[$];
        logic        seq[$];
        logic [22:0] seed_v;
        logic [3:0]  sym;
        logic        o;
        int          n;
        int          wait_cnt;
        int          last;
        seed_v = SEED;
        for (int i = 0; i < 23; i++) seq.push_back(seed_v[22 - i]);
        for (int k = 0; k < int'(PRE_LEN); k++)
            exp_q.push_back('{2'd1, (k % 2 == 1) ? 4'hC : 4'h3, 1'b1});
        for (int k = 0; k < len; k++) begin
            sym = '0;
            for (int b = 0; b < 4; b++) begin
                n = 4 * k + b;
                o = seq[n] ^ seq[n + 5];
                seq.push_back(o);
                sym[3 - b] = o;
            end
            exp_q.push_back('{2'd2, sym, 1'b1});
        end
        for (int k = 0; k < int'(GUARD_LEN); k++) exp_q.push_back('{2'd3, 4'h0, 1'b0});

        last     = exp_q.size() - 1;
        wait_cnt = first_delay;
        for (int s = 0; s <= last; s++) begin
            for (int c = 1; c < wait_cnt; c++) begin
                step();
                check("quiet_between_slots", 32'({sym_tick, sym_valid, frame_done}), 32'd0);
            end
            step();
            check("sym_tick", 32'(sym_tick), 32'd1);
            check("sym_valid", 32'(sym_valid), 32'(exp_q[s].valid));
            check("sym_bits", 32'(sym_bits), 32'(exp_q[s].bits));
            check("seg", 32'(seg), 32'(exp_q[s].seg));
            check("frame_done", 32'(frame_done), 32'(s == last));
            check("busy_in_frame", 32'(busy), 32'd1);
            if (s == last) begin
                fc_exp = (fc_exp + 1) % 65536;
                check("frame_count", 32'(frame_count), 32'(fc_exp));
            end
            wait_cnt = SPS;
            if (s == gap_slot) begin
                en = 1'b0;
                for (int g = 0; g < 7; g++) begin
                    step();
                    check("en_gap_quiet", 32'({sym_tick, sym_valid, frame_done}), 32'd0);
                end
                en = 1'b1;
            end else if (s == pulse_slot) begin
                if (pulse_kind == 1) stop = 1'b1;
                else start = 1'b1;
                step();
                stop  = 1'b0;
                start = 1'b0;
                check("quiet_after_pulse", 32'({sym_tick, sym_valid, frame_done}), 32'd0);
                wait_cnt = SPS - 1;
            end
        end
    endtask

    task automatic launch(input int len, input logic cont, input logic with_stop);
        payload_len = LEN_W'(len);
        continuous  = cont;
        start       = 1'b1;
        stop        = with_stop;
        step();
        start       = 1'b0;
        stop        = 1'b0;
        continuous  = 1'b0;
        payload_len = LEN_W'(3);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        step();
        check(tag, 32'({busy, seg}), 32'd0);
        for (int i = 0; i < 2 * SPS; i++) begin
            step();
            check("idle_no_tick", 32'({sym_tick, sym_valid, busy}), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        payload_len = '0;
        @(negedge clk);
        step();
        check("reset_outputs", 32'({sym_bits, sym_valid, sym_tick, seg, busy, frame_done}), 32'd0);
        check("reset_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        step();
        check("idle_after_reset", 32'({busy, sym_tick}), 32'd0);

        // Single frame, payload 8
        launch(8, 1'b0, 1'b0);
        run_frame(8, 1, -1, -1, 0);
        expect_idle("idle_after_single");

        // Empty payload goes straight from preamble to guard
        launch(0, 1'b0, 1'b0);
        run_frame(0, 1, -1, -1, 0);
        expect_idle("idle_after_empty");

        // Random lengths
        for (int r = 0; r < 2; r++) begin
            len_r = int'($urandom_range(1, 12));
            launch(len_r, 1'b0, 1'b0);
            run_frame(len_r, 1, -1, -1, 0);
            expect_idle("idle_after_random");
        end

        // Continuous, stop during second frame: two identical frames then idle
        len_r = int'($urandom_range(4, 10));
        launch(len_r, 1'b1, 1'b0);
        run_frame(len_r, 1, -1, -1, 0);
        run_frame(len_r, SPS, -1, 5, 1);
        expect_idle("idle_after_cont_stop");

        // en low for 7 cycles inside payload
        len_r = int'($urandom_range(5, 12));
        launch(len_r, 1'b0, 1'b0);
        run_frame(len_r, 1, int'(PRE_LEN) + 3, -1, 0);
        expect_idle("idle_after_en_gap");

        // start while busy is ignored
        len_r = int'($urandom_range(1, 8));
        launch(len_r, 1'b0, 1'b0);
        run_frame(len_r, 1, -1, 2, 2);
        expect_idle("idle_after_busy_start");

        // stop while idle has no effect on a following continuous run
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_in_idle", 32'(busy), 32'd0);
        len_r = int'($urandom_range(1, 6));
        launch(len_r, 1'b1, 1'b0);
        run_frame(len_r, 1, -1, -1, 0);
        run_frame(len_r, SPS, -1, 0, 1);
        expect_idle("idle_after_idle_stop");

        // start and stop together with continuous: exactly one frame
        len_r = int'($urandom_range(1, 6));
        launch(len_r, 1'b1, 1'b1);
        run_frame(len_r, 1, -1, -1, 0);
        expect_idle("idle_after_start_stop");

        // Reset mid-frame clears everything at once
        launch(6, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step();
        rst = 1'b1;
        #1;
        check("midframe_reset_outputs",
              32'({sym_bits, sym_valid, sym_tick, seg, busy, frame_done}), 32'd0);
        check("midframe_reset_count", 32'(frame_count), 32'd0);
        fc_exp = 0;
        @(negedge clk);
        rst = 1'b0;
        expect_idle("idle_after_midframe_reset");
        check("count_after_reset", 32'(frame_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
